// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch resolve, 32-cycle shift-add multiplier, EX/MEM latch.
// Optional OVF_TRAP_EN: signed ADD/SUB overflow sets ovf_o and suppresses RegWrite_o.
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
endpackage

module ex_stage
    import cpu_types_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] npc_i,
    input  logic [31:0] rdata1_i,
    input  logic [31:0] rdata2_i,
    input  logic [31:0] extout_i,
    input  logic [5:0]  shamt_i,
    input  logic [1:0]  ALUSrc_i,
    input  aluop_t      ALUop_i,
    input  logic        Branch_i,
    input  logic        bne_i,
    input  logic        mul_i,
    input  logic        DRen_i,
    input  logic        DWen_i,
    input  logic        RegWrite_i,
    input  logic        RegDst_i,
    input  logic        halt_i,
    input  logic        noop_i,
    input  logic [1:0]  MemtoReg_i,
    input  regbits_t    Rd_i,
    input  regbits_t    Rt_i,
    output logic [31:0] aluout_o,
    output logic [31:0] wdata_o,
    output regbits_t    wsel_o,
    output logic        DRen_o,
    output logic        DWen_o,
    output logic        RegWrite_o,
    output logic        halt_o,
    output logic [1:0]  MemtoReg_o,
    output logic [31:0] npc_o,
    output logic        br_taken_o,
    output logic [31:0] br_target_o,
    output logic        ex_busy_o,
    output logic        ovf_o
);
    localparam int CW = $clog2(MUL_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mstate_t;

    mstate_t       state_q;
    logic [31:0]   mcand_q, mplier_q, acc_q;
    logic [CW-1:0] cnt_q;

    logic [31:0] alu_b, alu_res, result_d, br_target_d;
    logic        load, br_taken_d;
    regbits_t    wsel_d;

    always_comb begin
        case (ALUSrc_i)
            2'd1:    alu_b = extout_i;
            2'd2:    alu_b = {26'b0, shamt_i};
            default: alu_b = rdata2_i;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ALUop_i)
            ALU_SLL:  alu_res = rdata1_i << alu_b[4:0];
            ALU_SRL:  alu_res = rdata1_i >> alu_b[4:0];
            ALU_SRA:  alu_res = $signed(rdata1_i) >>> alu_b[4:0];
            ALU_ADD:  alu_res = rdata1_i + alu_b;
            ALU_SUB:  alu_res = rdata1_i - alu_b;
            ALU_AND:  alu_res = rdata1_i & alu_b;
            ALU_OR:   alu_res = rdata1_i | alu_b;
            ALU_XOR:  alu_res = rdata1_i ^ alu_b;
            ALU_NOR:  alu_res = ~(rdata1_i | alu_b);
            ALU_SLT:  alu_res = {31'b0, $signed(rdata1_i) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'b0, rdata1_i < alu_b};
            default:  alu_res = '0;
        endcase
    end

    // Stall request is combinational so the hazard unit can freeze upstream this cycle.
    assign ex_busy_o   = (state_q == S_MUL) || (state_q == S_IDLE && mul_i && !noop_i);
    assign load        = en && !ex_busy_o && !flush;
    assign result_d    = (state_q == S_DONE) ? acc_q : alu_res;
    assign wsel_d      = RegDst_i ? Rd_i : Rt_i;
    assign br_taken_d  = Branch_i && !noop_i &&
                         (bne_i ? (rdata1_i != rdata2_i) : (rdata1_i == rdata2_i));
    assign br_target_d = npc_i + (extout_i << 2);

`ifdef OVF_TRAP_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = 1'b0;
        if (!noop_i && state_q != S_DONE) begin
            case (ALUop_i)
                ALU_ADD: ovf_d = (rdata1_i[31] == alu_b[31]) && (alu_res[31] != rdata1_i[31]);
                ALU_SUB: ovf_d = (rdata1_i[31] != alu_b[31]) && (alu_res[31] != rdata1_i[31]);
                default: ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) ovf_q <= 1'b0;
        else if (load)    ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic ovf_d;
    assign ovf_d = 1'b0;
    assign ovf_o = 1'b0;
`endif

    logic [31:0] aluout_q, wdata_q, npc_q, br_target_q;
    regbits_t    wsel_q;
    logic        dren_q, dwen_q, regwrite_q, halt_q, br_taken_q;
    logic [1:0]  memtoreg_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            aluout_q    <= '0;
            wdata_q     <= '0;
            wsel_q      <= '0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            regwrite_q  <= 1'b0;
            halt_q      <= 1'b0;
            memtoreg_q  <= '0;
            npc_q       <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else if (flush) begin
            // Bubble: data fields and the sticky halt keep their values.
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= '0;
            br_taken_q <= 1'b0;
        end else if (load) begin
            aluout_q    <= result_d;
            wdata_q     <= rdata2_i;
            wsel_q      <= wsel_d;
            dren_q      <= DRen_i && !noop_i;
            dwen_q      <= DWen_i && !noop_i;
            regwrite_q  <= RegWrite_i && !noop_i && !ovf_d;
            halt_q      <= halt_q || (halt_i && !noop_i);
            memtoreg_q  <= noop_i ? 2'b00 : MemtoReg_i;
            npc_q       <= npc_i;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    // Only the low product word is consumed, so 32-bit multiplicand/accumulator suffice.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (en && ex_busy_o) begin
                    mcand_q  <= rdata1_i;
                    mplier_q <= rdata2_i;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_MUL;
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MUL_CYCLES - 1)) state_q <= S_DONE;
                end
                S_DONE:  if (en) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign aluout_o    = aluout_q;
    assign wdata_o     = wdata_q;
    assign wsel_o      = wsel_q;
    assign DRen_o      = dren_q;
    assign DWen_o      = dwen_q;
    assign RegWrite_o  = regwrite_q;
    assign halt_o      = halt_q;
    assign MemtoReg_o  = memtoreg_q;
    assign npc_o       = npc_q;
    assign br_taken_o  = br_taken_q;
    assign br_target_o = br_target_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table, branch/multiply/flush/halt sequences, random vs model.
module tb_ex_stage;
    import cpu_types_pkg::*;

`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0, RST, en, flush;
    logic [31:0] npc_i, rdata1_i, rdata2_i, extout_i;
    logic [5:0]  shamt_i;
    logic [1:0]  ALUSrc_i, MemtoReg_i;
    aluop_t      ALUop_i;
    logic        Branch_i, bne_i, mul_i, DRen_i, DWen_i, RegWrite_i, RegDst_i, halt_i, noop_i;
    regbits_t    Rd_i, Rt_i;
    logic [31:0] aluout_o, wdata_o, npc_o, br_target_o;
    regbits_t    wsel_o;
    logic        DRen_o, DWen_o, RegWrite_o, halt_o, br_taken_o, ex_busy_o, ovf_o;
    logic [1:0]  MemtoReg_o;

    ex_stage dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .npc_i(npc_i),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .extout_i(extout_i), .shamt_i(shamt_i),
        .ALUSrc_i(ALUSrc_i), .ALUop_i(ALUop_i), .Branch_i(Branch_i), .bne_i(bne_i),
        .mul_i(mul_i), .DRen_i(DRen_i), .DWen_i(DWen_i), .RegWrite_i(RegWrite_i),
        .RegDst_i(RegDst_i), .halt_i(halt_i), .noop_i(noop_i), .MemtoReg_i(MemtoReg_i),
        .Rd_i(Rd_i), .Rt_i(Rt_i), .aluout_o(aluout_o), .wdata_o(wdata_o), .wsel_o(wsel_o),
        .DRen_o(DRen_o), .DWen_o(DWen_o), .RegWrite_o(RegWrite_o), .halt_o(halt_o),
        .MemtoReg_o(MemtoReg_o), .npc_o(npc_o), .br_taken_o(br_taken_o),
        .br_target_o(br_target_o), .ex_busy_o(ex_busy_o), .ovf_o(ovf_o)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] aluout, wdata, npc, br_target;
        regbits_t    wsel;
        logic        dren, dwen, regwrite, halt, br_taken, ovf;
        logic [1:0]  memtoreg;
    } exm_t;

    typedef struct {
        aluop_t      op;
        logic [31:0] a, b, ext;
        logic [5:0]  sh;
        logic [1:0]  src;
        logic [31:0] exp;
        bit          ovf;
    } vec_t;

    vec_t tbl[13];
    exm_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        en = 0; flush = 0; npc_i = 0; rdata1_i = 0; rdata2_i = 0; extout_i = 0; shamt_i = 0;
        ALUSrc_i = 0; ALUop_i = ALU_ADD; Branch_i = 0; bne_i = 0; mul_i = 0; DRen_i = 0;
        DWen_i = 0; RegWrite_i = 0; RegDst_i = 0; halt_i = 0; noop_i = 0; MemtoReg_i = 0;
        Rd_i = 0; Rt_i = 0;
    endtask

    task automatic rand_inputs();
        npc_i = $urandom; rdata1_i = $urandom; rdata2_i = $urandom; extout_i = $urandom;
        shamt_i = 6'($urandom); ALUSrc_i = 2'($urandom); MemtoReg_i = 2'($urandom);
        ALUop_i = aluop_t'($urandom_range(0, 10));
        Branch_i = 1'($urandom); bne_i = 1'($urandom); DRen_i = 1'($urandom);
        DWen_i = 1'($urandom); RegWrite_i = 1'($urandom); RegDst_i = 1'($urandom);
        Rd_i = 5'($urandom); Rt_i = 5'($urandom);
        mul_i = 0; halt_i = 0;
        noop_i = ($urandom_range(0, 9) == 0);
        flush  = ($urandom_range(0, 9) == 0);
        en     = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) rdata2_i = rdata1_i;
        if ($urandom_range(0, 5) == 0) rdata1_i = 32'h7FFFFFFF;
        if ($urandom_range(0, 5) == 0) rdata1_i = 32'h80000000;
    endtask

    function automatic logic [31:0] alu_ref(aluop_t op, logic [31:0] a, logic [31:0] b);
        int unsigned s = b % 32;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a * (32'd1 << s);
            ALU_SRL:  return a / (32'd1 << s);
            ALU_SRA:  return $signed(a) >>> s;
            default:  return 32'd0;
        endcase
    endfunction

    // Overflow judged from the true (wide) signed result leaving the 32-bit range.
    function automatic bit ovf_ref(aluop_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == ALU_ADD) r = sa + sb;
        else if (op == ALU_SUB) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic exm_t ref_load(exm_t prev);
        exm_t e;
        logic [31:0] b;
        b = (ALUSrc_i == 2'd1) ? extout_i : (ALUSrc_i == 2'd2) ? {26'b0, shamt_i} : rdata2_i;
        e.aluout    = alu_ref(ALUop_i, rdata1_i, b);
        e.ovf       = TRAP && !noop_i && ovf_ref(ALUop_i, rdata1_i, b);
        e.wdata     = rdata2_i;
        e.wsel      = RegDst_i ? Rd_i : Rt_i;
        e.dren      = DRen_i && !noop_i;
        e.dwen      = DWen_i && !noop_i;
        e.regwrite  = RegWrite_i && !noop_i && !e.ovf;
        e.memtoreg  = noop_i ? 2'b00 : MemtoReg_i;
        e.npc       = npc_i;
        e.br_taken  = Branch_i && !noop_i && (bne_i ? rdata1_i != rdata2_i : rdata1_i == rdata2_i);
        e.br_target = npc_i + extout_i * 4;
        e.halt      = prev.halt || halt_i;
        return e;
    endfunction

    task automatic check_all(input exm_t e);
        chk("aluout", aluout_o, e.aluout);
        chk("wdata", wdata_o, e.wdata);
        chk("wsel", 32'(wsel_o), 32'(e.wsel));
        chk("dren", 32'(DRen_o), 32'(e.dren));
        chk("dwen", 32'(DWen_o), 32'(e.dwen));
        chk("regwrite", 32'(RegWrite_o), 32'(e.regwrite));
        chk("memtoreg", 32'(MemtoReg_o), 32'(e.memtoreg));
        chk("npc", npc_o, e.npc);
        chk("br_taken", 32'(br_taken_o), 32'(e.br_taken));
        chk("br_target", br_target_o, e.br_target);
        chk("halt", 32'(halt_o), 32'(e.halt));
        chk("ovf", 32'(ovf_o), 32'(e.ovf));
    endtask

    initial begin
        int cycles;
        exm_t z;
        z = '{default: '0};

        tbl[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h0,  6'd0,  2'd0, 32'h80000000, 1'b1};
        tbl[1]  = '{ALU_SUB,  32'h0,        32'h1,        32'h0,  6'd0,  2'd0, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,  6'd0,  2'd0, 32'hF000F000, 1'b0};
        tbl[3]  = '{ALU_OR,   32'h0F0F0000, 32'h0,        32'hFF, 6'd0,  2'd1, 32'h0F0F00FF, 1'b0};
        tbl[4]  = '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0,  6'd0,  2'd0, 32'hF0F00F0F, 1'b0};
        tbl[5]  = '{ALU_NOR,  32'h0,        32'h0,        32'h0,  6'd0,  2'd0, 32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h0,  6'd0,  2'd0, 32'h1,        1'b0};
        tbl[7]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,  6'd0,  2'd0, 32'h0,        1'b0};
        tbl[8]  = '{ALU_SLL,  32'h1,        32'h0,        32'h0,  6'd31, 2'd2, 32'h80000000, 1'b0};
        tbl[9]  = '{ALU_SRA,  32'h80000000, 32'h0,        32'h0,  6'd4,  2'd2, 32'hF8000000, 1'b0};
        tbl[10] = '{ALU_SRL,  32'h80000000, 32'h0,        32'h24, 6'd0,  2'd1, 32'h08000000, 1'b0};
        tbl[11] = '{ALU_ADD,  32'h5,        32'h7,        32'h99, 6'd9,  2'd3, 32'h0000000C, 1'b0};
        tbl[12] = '{ALU_SUB,  32'h80000000, 32'h1,        32'h0,  6'd0,  2'd0, 32'h7FFFFFFF, 1'b1};

        // Reset with random inputs
        clr_inputs();
        RST = 1;
        rand_inputs(); tick();
        rand_inputs(); tick();
        mul_i = 0;
        #1;
        check_all(z);
        chk("reset_busy", 32'(ex_busy_o), 32'd0);
        RST = 0;
        clr_inputs();

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            ALUop_i = tbl[i].op; rdata1_i = tbl[i].a; rdata2_i = tbl[i].b;
            extout_i = tbl[i].ext; shamt_i = tbl[i].sh; ALUSrc_i = tbl[i].src;
            RegWrite_i = 1; en = 1;
            tick();
            chk($sformatf("vec%0d_aluout", i), aluout_o, tbl[i].exp);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_o), 32'(TRAP && tbl[i].ovf));
            chk($sformatf("vec%0d_regwrite", i), 32'(RegWrite_o), 32'(!(TRAP && tbl[i].ovf)));
        end

        // Branch: BEQ taken, BNE not taken, BNE taken; B ignores ALUSrc
        clr_inputs();
        en = 1; Branch_i = 1; rdata1_i = 5; rdata2_i = 5; npc_i = 32'h104;
        extout_i = 32'hFFFFFFFE; ALUSrc_i = 2'd1;
        tick();
        chk("beq_taken", 32'(br_taken_o), 32'd1);
        chk("beq_target", br_target_o, 32'hFC);
        bne_i = 1;
        tick();
        chk("bne_equal", 32'(br_taken_o), 32'd0);
        chk("bne_target", br_target_o, 32'hFC);
        rdata2_i = 6;
        tick();
        chk("bne_differ", 32'(br_taken_o), 32'd1);

        // Multiply: 33 busy cycles, then low word loaded
        clr_inputs();
        mul_i = 1; rdata1_i = 32'h10001; rdata2_i = 32'h10001; RegWrite_i = 1; en = 1;
        #1;
        cycles = 0;
        while (ex_busy_o && cycles < 100) begin
            tick();
            cycles++;
        end
        chk("mul_busy_cycles", 32'(cycles), 32'd33);
        tick();
        mul_i = 0;
        chk("mul_result", aluout_o, 32'h00020001);
        chk("mul_regwrite", 32'(RegWrite_o), 32'd1);

        // Multiply aborted by flush after 10 cycles
        mul_i = 1; rdata1_i = 3; rdata2_i = 4; RegWrite_i = 1; en = 1;
        repeat (10) tick();
        chk("mulstall_busy", 32'(ex_busy_o), 32'd1);
        chk("mulstall_hold", aluout_o, 32'h00020001);
        flush = 1; mul_i = 0;
        tick();
        chk("flush_busy", 32'(ex_busy_o), 32'd0);
        chk("flush_regwrite", 32'(RegWrite_o), 32'd0);
        chk("flush_brtaken", 32'(br_taken_o), 32'd0);
        chk("flush_dren", 32'(DRen_o), 32'd0);
        chk("flush_memtoreg", 32'(MemtoReg_o), 32'd0);
        chk("flush_data_hold", aluout_o, 32'h00020001);
        flush = 0; ALUop_i = ALU_ADD; rdata1_i = 2; rdata2_i = 3;
        tick();
        chk("post_flush_add", aluout_o, 32'h5);
        chk("post_flush_regwrite", 32'(RegWrite_o), 32'd1);

        // Random traffic against the reference model
        clr_inputs();
        RST = 1;
        tick();
        RST = 0;
        m = z;
        for (int n = 0; n < 200; n++) begin
            rand_inputs();
            if (flush) begin
                m.dren = 0; m.dwen = 0; m.regwrite = 0; m.memtoreg = 0; m.br_taken = 0; m.ovf = 0;
            end else if (en) begin
                m = ref_load(m);
            end
            tick();
            check_all(m);
        end

        // Sticky halt
        clr_inputs();
        RST = 1;
        tick();
        RST = 0;
        halt_i = 1; en = 1;
        tick();
        chk("halt_set", 32'(halt_o), 32'd1);
        halt_i = 0; flush = 1;
        tick();
        chk("halt_after_flush", 32'(halt_o), 32'd1);
        flush = 0;
        tick();
        chk("halt_after_load1", 32'(halt_o), 32'd1);
        tick();
        chk("halt_after_load2", 32'(halt_o), 32'd1);
        RST = 1;
        tick();
        chk("halt_cleared", 32'(halt_o), 32'd0);
        RST = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX latch outputs and computes the ALU result, store data and destination register.
- Resolves conditional branches and runs an iterative 32-cycle multiplier that stalls the pipeline while busy.
- Registers everything into the EX/MEM latch, which feeds the MEM stage and the PC redirect logic.

Parameters:
- MUL_CYCLES, 32, iterations of the shift-add multiplier (one per multiplier bit).

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- en  input  1  pipeline advance from hazard unit (ihit/dhit qualified)
- flush  input  1  squash EX/MEM contents (bubble)
- npc_i  input  32  PC+4 of the instruction
- rdata1_i, rdata2_i  input  32  register operands A, B
- extout_i  input  32  extended immediate
- shamt_i  input  6  shift amount
- ALUSrc_i  input  2  B select: 0 rdata2, 1 extout, 2 zero-extended shamt, 3 rdata2
- ALUop_i  input  aluop_t  ALU function (cpu_types_pkg)
- Branch_i, bne_i  input  1  branch instruction; 1 = BNE, 0 = BEQ
- mul_i  input  1  unsigned multiply, low word to rd
- DRen_i, DWen_i, RegWrite_i, RegDst_i, halt_i, noop_i  input  1  control from ID/EX
- MemtoReg_i  input  2  writeback select
- Rd_i, Rt_i  input  regbits_t  destination candidates
- aluout_o  output  32  ALU or multiply result
- wdata_o  output  32  store data (rdata2_i)
- wsel_o  output  regbits_t  RegDst_i ? Rd_i : Rt_i
- DRen_o, DWen_o, RegWrite_o, halt_o  output  1  registered control
- MemtoReg_o  output  2  registered
- npc_o  output  32  registered npc_i
- br_taken_o  output  1  registered branch decision
- br_target_o  output  32  registered npc_i + (extout_i << 2)
- ex_busy_o  output  1  combinational stall request to hazard unit
- ovf_o  output  1  overflow flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; multiply counter 0.
- EX/MEM register update priority: RST > flush > (en & !ex_busy_o) load > hold.
- Flush: all control outputs (DRen, DWen, RegWrite, br_taken, MemtoReg) go to 0. Data outputs hold their previous values.
- noop_i on load: behaves as a flush bubble; all control outputs are 0.
- halt_o is sticky. Once loaded as 1 it stays 1 until RST, even across loads and flushes.
- ALU:
  - 32-bit wrap-around arithmetic.
  - Shifts use B[4:0].
  - SLT is signed; SLTU is unsigned.
- Branch:
  - taken = Branch_i & !noop_i & (bne_i ? A != B : A == B), with B always rdata2_i.
  - Target arithmetic wraps modulo 2^32.
  - Registered with the EX/MEM load, so the redirect is visible one cycle after load.
- Multiplier FSM:
  - IDLE: ex_busy_o = mul_i & !noop_i. When en & ex_busy_o and not flush, latch the operands, clear the accumulator, set count = 0, go to MUL.
  - MUL: ex_busy_o = 1. Each cycle, if multiplier bit 0 is set add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right; count++. After MUL_CYCLES iterations go to DONE.
  - DONE: ex_busy_o = 0; aluout source = accumulator low 32 bits. On a load, return to IDLE. Otherwise hold in DONE.
  - flush in any state returns the FSM to IDLE and discards the partial product.
  - RST in any state returns the FSM to IDLE.
  - Total latency of a multiply is MUL_CYCLES + 1 cycles from entry to EX/MEM load.
- wsel_o is selected combinationally from the inputs and registered on load.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined: signed overflow on ADD/SUB sets ovf_o on load, and the same load forces RegWrite_o = 0. ovf_o clears on the next load, flush or RST.
- Undefined: ovf_o is constant 0, and ADD/SUB wrap silently.

Test Plan:
- RST held 2 cycles with random inputs -> all outputs 0; ex_busy_o = 0.
- ADD A = 0x7FFFFFFF, B = 1, en = 1 -> aluout_o = 0x80000000 next cycle. With OVF_TRAP_EN: ovf_o = 1 and RegWrite_o = 0.
- BEQ A = B = 5, npc_i = 0x104, extout_i = 0xFFFFFFFE, en = 1 -> br_taken_o = 1, br_target_o = 0xFC. Same case with bne_i = 1 -> br_taken_o = 0.
- mul_i, A = 0x10001, B = 0x10001, en held 1 -> ex_busy_o high 33 cycles; then aluout_o = 0x00020001 and RegWrite_o = 1.
- Multiply started, flush asserted at cycle 10 -> ex_busy_o drops; FSM in IDLE; all control outputs 0. Next ADD completes in 1 cycle.
- halt_i = 1 loaded, then flush, then further loads with halt_i = 0 -> halt_o remains 1 until RST.
